// File: rtl/alu_pkg.sv
// Shared arithmetic definitions: divider FSM states and the default datapath width.
package alu_pkg;
  localparam int ALU_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor magnitude, keep the difference only when it did not borrow.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < dvs always holds, so a non-borrowing difference fits in WIDTH bits
  // and a borrow always shows up in the extra top bit.
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/arith_divider.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready handshakes on
// both sides; one quotient bit per cycle, zero-divisor and overflow short-cuts.
module arith_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state_reg, state_next;
  logic             accept;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rmd_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             dz_case, ov_case;
  logic [WIDTH-1:0] step_rem, q_mag;
  logic             step_q, last_step;

  assign a_mag   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign dz_case = (divisor == '0);
  assign ov_case = is_signed && (dividend == MOST_NEG) && (divisor == '1);

  // dvd_reg shifts the dividend out at the top while quotient bits enter at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_reg),
    .dvd_bit(dvd_reg[WIDTH-1]),
    .dvs    (dvs_reg),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  assign q_mag     = {dvd_reg[WIDTH-2:0], step_q};
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = (dz_case || ov_case) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      quo_reg   <= '0;
      rmd_reg   <= '0;
      dbz_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      if (dz_case) begin
        quo_reg <= '1;
        rmd_reg <= dividend;
        dbz_reg <= 1'b1;
        ovf_reg <= 1'b0;
      end else if (ov_case) begin
        quo_reg <= dividend;
        rmd_reg <= '0;
        dbz_reg <= 1'b0;
        ovf_reg <= 1'b1;
      end else begin
        cnt_reg   <= '0;
        rem_reg   <= '0;
        dvd_reg   <= a_mag;
        dvs_reg   <= b_mag;
        neg_q_reg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_reg <= is_signed && dividend[WIDTH-1];
        dbz_reg   <= 1'b0;
        ovf_reg   <= 1'b0;
      end
    end else if (state_reg == CALC) begin
      rem_reg <= step_rem;
      dvd_reg <= q_mag;
      if (last_step) begin
        // Sign fix-up folds into the final step so DONE presents finished values.
        cnt_reg <= '0;
        quo_reg <= neg_q_reg ? -q_mag : q_mag;
        rmd_reg <= neg_r_reg ? -step_rem : step_rem;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign quotient    = quo_reg;
  assign remainder   = rmd_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;
endmodule
